conv_krn3x3: RTL

CONV_KRN3X3 -- requirements
Module: conv_krn3x3

---
 rtl/conv_krn3x3.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/conv_krn3x3.sv
// conv_krn3x3 -- streaming 3x3 convolution kernel.
//
// Takes one column of three vertically adjacent pixels per accepted beat,
// keeps a 3x3 window, and produces one filtered pixel for every window
// that holds three columns of the current line.
//
// Pipeline: window register -> row partial sums -> final add/shift/clamp.
// Latency from the window-completing beat to pixel_vld_o is 3 cycles.
//
// Ports:
//   clk          clock, rising edge
//   arst_n       asynchronous active-low reset
//   col_vld_i    column beat valid (no backpressure)
//   col_dat_i    column pixels, [0] = top (oldest row), [2] = bottom
//   col_eol_i    last column of the line (qualified by col_vld_i)
//   coef_i       9 signed 4-bit taps, index row*3+col, col 0 = oldest
//   pixel_vld_o  filtered pixel valid
//   pixel_dat_o  filtered pixel, clamped to the pixel range
//   pixel_eol_o  last filtered pixel of the line

package conv_pkg;
  typedef logic [7:0]        pixel_t;
  typedef logic signed [3:0] coef_t;
endpackage

module conv_krn3x3 #(
  parameter int unsigned SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    col_vld_i,
  input  conv_pkg::pixel_t [2:0]  col_dat_i,
  input  logic                    col_eol_i,
  input  conv_pkg::coef_t  [8:0]  coef_i,
  output logic                    pixel_vld_o,
  output conv_pkg::pixel_t        pixel_dat_o,
  output logic                    pixel_eol_o
);

  localparam int unsigned PIXEL_W = $bits(conv_pkg::pixel_t);
  localparam int unsigned SUM_W   = PIXEL_W + 9;
  localparam logic signed [SUM_W-1:0] PIX_MAX =
    {{(SUM_W-PIXEL_W){1'b0}}, {PIXEL_W{1'b1}}};

  typedef enum logic [1:0] {FILL0, FILL1, RUN} state_e;

  state_e state_q, state_d;
  logic   win_ok;

  // win_q[row][col], col 2 is the newest column
  conv_pkg::pixel_t [2:0][2:0] win_q;
  logic                        win_vld_q, win_eol_q;

  logic signed [SUM_W-1:0] rsum_q [3];
  logic signed [SUM_W-1:0] rsum_d [3];
  logic                    p_vld_q, p_eol_q;

  logic signed [SUM_W-1:0] total, shifted;
  conv_pkg::pixel_t        clamp;

  logic             out_vld_q, out_eol_q;
  conv_pkg::pixel_t out_dat_q;

  // Line-fill tracking; a window is complete on the third and later beats.
  always_comb begin
    state_d = state_q;
    win_ok  = 1'b0;
    if (col_vld_i) begin
      win_ok = (state_q == RUN);
      if (col_eol_i) begin
        state_d = FILL0;
      end else begin
        unique case (state_q)
          FILL0:   state_d = FILL1;
          FILL1:   state_d = RUN;
          default: state_d = RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= FILL0;
    end else begin
      state_q <= state_d;
    end
  end

  // Window shift register; bubbles leave it untouched.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      win_q     <= '0;
      win_vld_q <= 1'b0;
      win_eol_q <= 1'b0;
    end else begin
      win_vld_q <= win_ok;
      win_eol_q <= col_vld_i & col_eol_i;
      if (col_vld_i) begin
        for (int unsigned r = 0; r < 3; r++) begin
          win_q[2'(r)][0] <= win_q[2'(r)][1];
          win_q[2'(r)][1] <= win_q[2'(r)][2];
          win_q[2'(r)][2] <= col_dat_i[2'(r)];
        end
      end
    end
  end

  // Row partial sums: signed tap times zero-extended pixel.
  always_comb begin
    logic signed [SUM_W-1:0] cx, px;
    for (int unsigned r = 0; r < 3; r++) begin
      rsum_d[2'(r)] = '0;
      for (int unsigned c = 0; c < 3; c++) begin
        cx = {{(SUM_W-4){coef_i[4'(r*3+c)][3]}}, coef_i[4'(r*3+c)]};
        px = {{(SUM_W-PIXEL_W){1'b0}}, win_q[2'(r)][2'(c)]};
        rsum_d[2'(r)] = rsum_d[2'(r)] + cx * px;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int unsigned r = 0; r < 3; r++) rsum_q[2'(r)] <= '0;
      p_vld_q <= 1'b0;
      p_eol_q <= 1'b0;
    end else begin
      p_vld_q <= win_vld_q;
      p_eol_q <= win_eol_q & win_vld_q;
      if (win_vld_q) begin
        for (int unsigned r = 0; r < 3; r++) rsum_q[2'(r)] <= rsum_d[2'(r)];
      end
    end
  end

  // Final add, arithmetic shift, clamp to [0, 2^PIXEL_W-1].
  always_comb begin
    total   = rsum_q[0] + rsum_q[1] + rsum_q[2];
    shifted = total >>> SHIFT;
    if (shifted[SUM_W-1]) begin
      clamp = '0;
    end else if (shifted > PIX_MAX) begin
      clamp = '1;
    end else begin
      clamp = shifted[PIXEL_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      out_eol_q <= 1'b0;
    end else begin
      out_vld_q <= p_vld_q;
      if (p_vld_q) begin
        out_dat_q <= clamp;
        out_eol_q <= p_eol_q;
      end
    end
  end

  assign pixel_vld_o = out_vld_q;
  assign pixel_dat_o = out_dat_q;
  assign pixel_eol_o = out_eol_q;

endmodule
